// File: rtl/dsp_pipe_stage.sv
// Configurable-depth pipeline register with a travelling valid flag, synchronous
// flush and a registered occupancy count. DEPTH=0 degenerates to a pure extender.

module dsp_pipe_stage_reg #(
  parameter int W = 36
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CE,
  input  logic         FLUSH,
  input  logic [W-1:0] d,
  input  logic         d_vld,
  output logic [W-1:0] q,
  output logic         q_vld
);
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q     <= '0;
      q_vld <= 1'b0;
    end else if (FLUSH) begin
      q     <= '0;
      q_vld <= 1'b0;
    end else if (CE) begin
      q     <= d;
      q_vld <= d_vld;
    end
  end
endmodule

module dsp_pipe_stage #(
  parameter int IN_W   = 18,
  parameter int OUT_W  = 36,
  parameter int DEPTH  = 1,
  parameter int SIGNED = 1,
  parameter int FILL_W = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CE,
  input  logic              FLUSH,
  input  logic [IN_W-1:0]   IN,
  input  logic              IN_VLD,
  output logic [OUT_W-1:0]  OUT,
  output logic              OUT_VLD,
  output logic [FILL_W-1:0] FILL
);
  logic [OUT_W-1:0] ext;

  generate
    if (OUT_W < IN_W) begin : g_bad_w
      $error("dsp_pipe_stage: OUT_W must be >= IN_W");
    end else if (OUT_W == IN_W) begin : g_ext_none
      assign ext = IN;
    end else if (SIGNED != 0) begin : g_ext_sign
      assign ext = {{(OUT_W-IN_W){IN[IN_W-1]}}, IN};
    end else begin : g_ext_zero
      assign ext = {{(OUT_W-IN_W){1'b0}}, IN};
    end

    if (DEPTH < 0 || DEPTH > 4) begin : g_bad_depth
      $error("dsp_pipe_stage: DEPTH must be 0..4");
    end
    if (FILL_W < $clog2(DEPTH+1)) begin : g_bad_fill
      $error("dsp_pipe_stage: FILL_W too narrow for DEPTH");
    end

    if (DEPTH == 0) begin : g_bypass
      // Control inputs are deliberately ignored in bypass mode.
      logic unused_ctl;
      assign unused_ctl = ^{CLK, RST, CE, FLUSH};
      assign OUT     = ext;
      assign OUT_VLD = IN_VLD;
      assign FILL    = '0;
    end else begin : g_pipe
      logic [DEPTH:0][OUT_W-1:0] dat_pipe;
      logic [DEPTH:0]            vld_pipe;
      logic [FILL_W-1:0]         fill_q;

      assign dat_pipe[0] = ext;
      assign vld_pipe[0] = IN_VLD;

      for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        dsp_pipe_stage_reg #(.W(OUT_W)) u_reg (
          .CLK   (CLK),
          .RST   (RST),
          .CE    (CE),
          .FLUSH (FLUSH),
          .d     (dat_pipe[s]),
          .d_vld (vld_pipe[s]),
          .q     (dat_pipe[s+1]),
          .q_vld (vld_pipe[s+1])
        );
      end

      // Occupancy tracks the valid flags: +1 on entry, -1 on exit from the last stage.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST)        fill_q <= '0;
        else if (FLUSH) fill_q <= '0;
        else if (CE)    fill_q <= fill_q + FILL_W'(IN_VLD) - FILL_W'(vld_pipe[DEPTH]);
      end

      assign OUT     = dat_pipe[DEPTH];
      assign OUT_VLD = vld_pipe[DEPTH];
      assign FILL    = fill_q;
    end
  endgenerate
endmodule

// File: tb/tb_dsp_pipe_stage.sv
// Randomized bench for dsp_pipe_stage: five configurations share one stimulus
// stream and are compared against a history-of-accepted-words reference model.

module tb_dsp_pipe_stage;
  logic        CLK, RST, CE, FLUSH, IN_VLD;
  logic [17:0] IN;

  logic [35:0] o0, o2s, o2u, o3;
  logic [17:0] o4;
  logic        v0, v2s, v2u, v3, v4;
  logic [2:0]  f0, f2s, f2u, f3, f4;

  dsp_pipe_stage #(.IN_W(18), .OUT_W(36), .DEPTH(0), .SIGNED(1), .FILL_W(3)) u0 (
    .CLK(CLK), .RST(RST), .CE(CE), .FLUSH(FLUSH), .IN(IN), .IN_VLD(IN_VLD),
    .OUT(o0), .OUT_VLD(v0), .FILL(f0));
  dsp_pipe_stage #(.IN_W(18), .OUT_W(36), .DEPTH(2), .SIGNED(1), .FILL_W(3)) u2s (
    .CLK(CLK), .RST(RST), .CE(CE), .FLUSH(FLUSH), .IN(IN), .IN_VLD(IN_VLD),
    .OUT(o2s), .OUT_VLD(v2s), .FILL(f2s));
  dsp_pipe_stage #(.IN_W(18), .OUT_W(36), .DEPTH(2), .SIGNED(0), .FILL_W(3)) u2u (
    .CLK(CLK), .RST(RST), .CE(CE), .FLUSH(FLUSH), .IN(IN), .IN_VLD(IN_VLD),
    .OUT(o2u), .OUT_VLD(v2u), .FILL(f2u));
  dsp_pipe_stage #(.IN_W(18), .OUT_W(36), .DEPTH(3), .SIGNED(1), .FILL_W(3)) u3 (
    .CLK(CLK), .RST(RST), .CE(CE), .FLUSH(FLUSH), .IN(IN), .IN_VLD(IN_VLD),
    .OUT(o3), .OUT_VLD(v3), .FILL(f3));
  dsp_pipe_stage #(.IN_W(18), .OUT_W(18), .DEPTH(4), .SIGNED(0), .FILL_W(3)) u4 (
    .CLK(CLK), .RST(RST), .CE(CE), .FLUSH(FLUSH), .IN(IN), .IN_VLD(IN_VLD),
    .OUT(o4), .OUT_VLD(v4), .FILL(f4));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: every word accepted on a CE edge since the last clear, oldest first.
  typedef struct { logic [17:0] d; bit v; } ent_t;
  ent_t hist[$];

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [35:0] ext(input logic [17:0] x, input bit sgn, input int ow);
    if (ow == 18 || !sgn) return {18'b0, x};
    return {{18{x[17]}}, x};
  endfunction

  // A depth-d pipe shows the word accepted d CE edges ago, or zero if none.
  function automatic ent_t tail(input int d);
    ent_t e;
    e.d = '0;
    e.v = 1'b0;
    if (hist.size() >= d) e = hist[hist.size()-d];
    return e;
  endfunction

  function automatic int cnt(input int d);
    int n = 0;
    for (int i = 0; i < d; i++)
      if (hist.size() > i && hist[hist.size()-1-i].v) n++;
    return n;
  endfunction

  task automatic model_edge();
    ent_t e;
    if (RST || FLUSH) hist.delete();
    else if (CE) begin
      e.d = IN;
      e.v = IN_VLD;
      hist.push_back(e);
      if (hist.size() > 8) void'(hist.pop_front());
    end
  endtask

  task automatic check_all(input string tag);
    ent_t e;
    chk({tag, "/d0.out"}, o0, ext(IN, 1, 36));
    chk({tag, "/d0.vld"}, {35'b0, v0}, {35'b0, IN_VLD});
    chk({tag, "/d0.fill"}, {33'b0, f0}, 36'd0);
    e = tail(2);
    chk({tag, "/d2s.out"}, o2s, ext(e.d, 1, 36));
    chk({tag, "/d2u.out"}, o2u, ext(e.d, 0, 36));
    chk({tag, "/d2s.vld"}, {35'b0, v2s}, {35'b0, e.v});
    chk({tag, "/d2u.vld"}, {35'b0, v2u}, {35'b0, e.v});
    chk({tag, "/d2.fill"}, {33'b0, f2s}, 36'(cnt(2)));
    chk({tag, "/d2u.fill"}, {33'b0, f2u}, 36'(cnt(2)));
    e = tail(3);
    chk({tag, "/d3.out"}, o3, ext(e.d, 1, 36));
    chk({tag, "/d3.vld"}, {35'b0, v3}, {35'b0, e.v});
    chk({tag, "/d3.fill"}, {33'b0, f3}, 36'(cnt(3)));
    e = tail(4);
    chk({tag, "/d4.out"}, {18'b0, o4}, ext(e.d, 0, 18));
    chk({tag, "/d4.vld"}, {35'b0, v4}, {35'b0, e.v});
    chk({tag, "/d4.fill"}, {33'b0, f4}, 36'(cnt(4)));
  endtask

  task automatic step(input string tag);
    @(posedge CLK);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input logic vld, input logic [17:0] d);
    IN_VLD = vld;
    IN     = d;
  endtask

  initial begin
    RST = 1'b1; CE = 1'b0; FLUSH = 1'b0; IN = '0; IN_VLD = 1'b0;
    #3 check_all("reset");
    step("reset_hold");
    RST = 1'b0;

    // Latency and extension
    CE = 1'b1;
    set_in(1'b1, 18'h20001);
    step("lat0");
    set_in(1'b0, 18'($urandom));
    step("lat1");
    chk("lat.sext", o2s, 36'hFFFFE0001);
    chk("lat.zext", o2u, 36'h000020001);
    chk("lat.vld", {35'b0, v2s}, 36'd1);
    set_in(1'b0, 18'($urandom));
    step("lat2");
    chk("lat.vld_once", {35'b0, v2s}, 36'd0);

    // CE stall with a full DEPTH=3 pipe
    FLUSH = 1'b1; step("stall_flush"); FLUSH = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 18'($urandom));
      step("stall_push");
    end
    CE = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in(1'($urandom), 18'($urandom));
      step("stall_hold");
      chk("stall.fill3", {33'b0, f3}, 36'd3);
    end
    CE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 18'($urandom));
      step("stall_drain");
      chk("stall.count", {33'b0, f3}, 36'(2 - i < 0 ? 0 : 2 - i));
    end

    // FILL pattern on DEPTH=4
    begin
      bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int r = 0; r < 3; r++)
        for (int i = 0; i < 6; i++) begin
          set_in(pat[i], 18'($urandom));
          step("fillpat");
          chk("fillpat.max4", {35'b0, (f4 <= 3'd4)}, 36'd1);
        end
    end

    // Flush priority over CE and an incoming valid word
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 18'($urandom));
      step("flush_pre");
    end
    FLUSH = 1'b1;
    set_in(1'b1, 18'h3ABCD);
    step("flush");
    chk("flush.out", o3, 36'd0);
    chk("flush.vld", {35'b0, v3}, 36'd0);
    chk("flush.fill", {33'b0, f3}, 36'd0);
    FLUSH = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 18'h00555);
      step("flush_post");
      chk("flush.never", {35'b0, (o4 == 18'h3ABCD)}, 36'd0);
    end

    // Asynchronous reset mid-stream with FILL=2 in the DEPTH=3 pipe
    set_in(1'b1, 18'($urandom)); step("rst_pre");
    set_in(1'b1, 18'($urandom)); step("rst_pre");
    chk("rst.fill_before", {33'b0, f3}, 36'd2);
    #2 RST = 1'b1;
    hist.delete();
    #1;
    check_all("rst_async");
    chk("rst.out", o3, 36'd0);
    chk("rst.vld", {35'b0, v3}, 36'd0);
    chk("rst.fill", {33'b0, f3}, 36'd0);
    set_in(1'b1, 18'($urandom));
    step("rst_held");
    RST = 1'b0;

    // Random traffic with occasional flush and async reset pulses
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        RST = 1'b1;
        hist.delete();
        #1 check_all("rnd_rst");
        #1 RST = 1'b0;
      end
      CE    = ($urandom_range(0, 3) != 0);
      FLUSH = ($urandom_range(0, 19) == 0);
      set_in(1'($urandom), 18'($urandom));
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
